avalon_burst_bram: RTL and testbench
====================================

AVALON_BURST_BRAM -- requirements
Module: avalon_burst_bram

Interface
REQ-001 The block SHALL take these parameters, one per line as name, default, meaning:
- DATA_W, 32, data width; multiple of 8, from 8 to 128.
- RAM_ADD_W, 8, log2 of the number of words (depth = 2**RAM_ADD_W).
- BURSTCOUNT_W, 4, burstcount width; the maximum burst is 2**(BURSTCOUNT_W-1).
- READ_LATENCY, 1, cycles from read acceptance to the first readdatavalid; legal values 1 or 2.
- WRAP_BURST, 0, burst address mode: 0 = incrementing, 1 = wrapping at a boundary aligned to 2**(BURSTCOUNT_W-1) words.

REQ-002 The block SHALL have one clock; reset is synchronous and active-high.

REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1, clock; all logic acts on the rising edge.
- reset, in, 1, synchronous, active-high reset.
- address, in, 32, byte address; the word index is (address >> log2(DATA_W/8)) mod depth.
- read, in, 1, read burst request.
- write, in, 1, write beat.
- burstcount, in, BURSTCOUNT_W, number of beats in the burst; sampled on the first beat only.
- byteenable, in, DATA_W/8, per-byte write mask.
- writedata, in, DATA_W, write data.
- readdata, out, DATA_W, read data; valid only while readdatavalid is high.
- readdatavalid, out, 1, one read beat is presented this cycle.
- waitrequest, out, 1, command not accepted this cycle.

Function
REQ-004 Memory SHALL be DATA_W/8 independent byte lanes of depth words each.

REQ-005 A beat SHALL count as accepted only when (read or write) is high and waitrequest is low in the same cycle.

REQ-006 The control FSM SHALL have four states: POST_RST, IDLE, RD_BURST and WR_BURST.

REQ-007 In IDLE, waitrequest SHALL be low.
- Accepted read: go to RD_BURST.
- Accepted write with burstcount > 1: go to WR_BURST.
- Accepted write with burstcount of 0 or 1: single write; stay in IDLE.

REQ-008 A burstcount of 0 SHALL be treated as 1.

REQ-009 When read and write are both high in IDLE, the write SHALL win and the read SHALL be ignored.

REQ-010 At the first beat of a burst, the block SHALL latch the start word index and the burst length.

REQ-011 Beat k (k = 0..len-1) SHALL use the following word index:
- WRAP_BURST = 0: (start + k) mod depth.
- WRAP_BURST = 1: start with its low BURSTCOUNT_W-1 bits replaced by (start + k) mod 2**(BURSTCOUNT_W-1).

REQ-012 Read burst timing, for a read accepted in cycle N:
- readdatavalid SHALL be high in cycles N+READ_LATENCY through N+READ_LATENCY+len-1, with no gaps.
- readdata SHALL carry word k in cycle N+READ_LATENCY+k.

REQ-013 In RD_BURST, waitrequest SHALL be high from N+1 through the last data cycle; the FSM SHALL return to IDLE after the last beat, so a new command can be accepted in the following cycle.

REQ-014 When readdatavalid is low, readdata SHALL be 0.

REQ-015 In WR_BURST, waitrequest SHALL be low. Each accepted write beat writes the lanes whose byteenable bit is 1, at the beat's word index. write low SHALL stall the burst without advancing it.

REQ-016 After the len-th accepted write beat, the FSM SHALL return to IDLE.

REQ-017 In WR_BURST, read SHALL be ignored.

REQ-018 A read of a word written in an earlier cycle SHALL return the new data; no same-cycle bypass is required.

REQ-019 The beat counter SHALL be BURSTCOUNT_W bits wide and SHALL never exceed len.

Reset
REQ-020 While reset is high, and for exactly one cycle after it falls (POST_RST), outputs SHALL be:
- waitrequest = 1.
- readdatavalid = 0.
- readdata = 0.

REQ-021 Reset SHALL clear the FSM to POST_RST, the beat counter to 0, the latched address to 0, the latched length to 1 and the read pipeline valid bits to 0. The FSM SHALL go from POST_RST to IDLE on the next cycle.

REQ-022 Reset asserted mid-burst SHALL abort the burst in the next cycle:
- No further readdatavalid is produced.
- No further memory write occurs.
- Memory contents are retained.
- Reset SHALL NOT initialise memory.

Verification
REQ-023 The bench SHALL cover these scenarios (DATA_W=32, RAM_ADD_W=8, BURSTCOUNT_W=4, READ_LATENCY=1 unless stated):
- Write single, address 0x10, data 0xDEADBEEF, byteenable 0xF; then read single at 0x10 -> readdatavalid exactly 1 cycle after acceptance, readdata 0xDEADBEEF, waitrequest high for that one cycle.
- Write burst of 4 at 0x3F8 (words 254, 255, 0, 1; write stalled for one cycle between beats 2 and 3); read burst of 4 from 0x3F8 -> 4 consecutive valid beats, returned in write order, showing wrap to word 0.
- WRAP_BURST=1, read burst of 8 starting at word 5 -> word order 5, 6, 7, 0, 1, 2, 3, 4.
- byteenable 0x5 writing 0xAABBCCDD over 0x11223344 -> read returns 0x11BB33DD.
- READ_LATENCY=2, burst of 3 -> first readdatavalid 2 cycles after acceptance; waitrequest high 4 cycles.
- Reset raised during beat 2 of an 8-beat read -> readdatavalid low the next cycle; waitrequest high through POST_RST; earlier-written data still readable afterwards.

Source files
------------

// File: rtl/avalon_burst_bram.sv
// Avalon-MM burst slave in front of a byte-lane block RAM.
// Incrementing or wrapping bursts, fixed read latency of 1 or 2 cycles.
module avalon_burst_bram #(
   parameter int DATA_W       = 32,
   parameter int RAM_ADD_W    = 8,
   parameter int BURSTCOUNT_W = 4,
   parameter int READ_LATENCY = 1,
   parameter int WRAP_BURST   = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             address,
   input  logic                    read,
   input  logic                    write,
   input  logic [BURSTCOUNT_W-1:0] burstcount,
   input  logic [DATA_W/8-1:0]     byteenable,
   input  logic [DATA_W-1:0]       writedata,
   output logic [DATA_W-1:0]       readdata,
   output logic                    readdatavalid,
   output logic                    waitrequest
);

   localparam int BYTES  = DATA_W / 8;
   localparam int OFF_W  = $clog2(BYTES);
   localparam int DEPTH  = 2 ** RAM_ADD_W;
   localparam int WRAP_W = BURSTCOUNT_W - 1;
   localparam logic [RAM_ADD_W-1:0] WRAP_MASK = RAM_ADD_W'((2 ** WRAP_W) - 1);

   typedef enum logic [1:0] {POST_RST, IDLE, RD_BURST, WR_BURST} state_t;

   state_t                  state_q, state_d;
   logic [BURSTCOUNT_W-1:0] cnt_q, cnt_d;
   logic [BURSTCOUNT_W-1:0] len_q, len_d;
   logic [RAM_ADD_W-1:0]    base_q, base_d;
   logic [READ_LATENCY:1]   vld_q;
   logic [DATA_W-1:0]       rdat1_q, rdat2_q, rdat_out;
   logic [7:0]              mem [BYTES][DEPTH];

   logic [RAM_ADD_W-1:0]    addr_idx, beat_sum, beat_idx, mem_idx;
   logic [BURSTCOUNT_W-1:0] req_len;
   logic                    rd_en, wr_en, wait_fsm, tail_pending, last_out;
   logic                    unused_addr;

   assign unused_addr = ^address;
   assign addr_idx    = address[OFF_W +: RAM_ADD_W];
   assign req_len     = (burstcount == '0) ? BURSTCOUNT_W'(1) : burstcount;
   assign beat_sum    = base_q + RAM_ADD_W'(cnt_q);
   assign beat_idx    = (WRAP_BURST != 0) ? ((base_q & ~WRAP_MASK) | (beat_sum & WRAP_MASK))
                                          : beat_sum;

   // The burst ends in the cycle its final beat leaves the pipe with nothing behind it.
   always_comb begin
      tail_pending = 1'b0;
      for (int i = 1; i < READ_LATENCY; i++) tail_pending = tail_pending | vld_q[i];
   end
   assign last_out = vld_q[READ_LATENCY] && !tail_pending;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      base_d   = base_q;
      wait_fsm = 1'b1;
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      mem_idx  = beat_idx;
      case (state_q)
         POST_RST: state_d = IDLE;
         IDLE: begin
            wait_fsm = 1'b0;
            mem_idx  = addr_idx;
            if (write) begin
               wr_en  = 1'b1;
               base_d = addr_idx;
               len_d  = req_len;
               cnt_d  = BURSTCOUNT_W'(1);
               if (req_len > BURSTCOUNT_W'(1)) state_d = WR_BURST;
            end else if (read) begin
               rd_en   = 1'b1;
               base_d  = addr_idx;
               len_d   = req_len;
               cnt_d   = BURSTCOUNT_W'(1);
               state_d = RD_BURST;
            end
         end
         RD_BURST: begin
            if (cnt_q < len_q) begin
               rd_en = 1'b1;
               cnt_d = cnt_q + BURSTCOUNT_W'(1);
            end else if (last_out) begin
               state_d = IDLE;
            end
         end
         WR_BURST: begin
            wait_fsm = 1'b0;
            if (write) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + BURSTCOUNT_W'(1);
               if (cnt_q + BURSTCOUNT_W'(1) == len_q) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A beat presented while reset is high is never accepted.
      if (reset) begin
         rd_en = 1'b0;
         wr_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= POST_RST;
         cnt_q   <= '0;
         len_q   <= BURSTCOUNT_W'(1);
         base_q  <= '0;
         vld_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         base_q   <= base_d;
         vld_q[1] <= rd_en;
         for (int i = 2; i <= READ_LATENCY; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   // Memory has no reset so contents survive a mid-burst abort.
   always_ff @(posedge clk) begin
      for (int b = 0; b < BYTES; b++) begin
         if (wr_en && byteenable[b]) mem[b][mem_idx] <= writedata[8*b +: 8];
         if (rd_en) rdat1_q[8*b +: 8] <= mem[b][mem_idx];
      end
      rdat2_q <= rdat1_q;
   end

   assign rdat_out      = (READ_LATENCY == 2) ? rdat2_q : rdat1_q;
   assign readdatavalid = vld_q[READ_LATENCY] && !reset;
   assign readdata      = readdatavalid ? rdat_out : '0;
   assign waitrequest   = wait_fsm || reset;

endmodule

// File: tb/tb_avalon_burst_bram.sv
// Bench for avalon_burst_bram: three instances (incrementing/RL1, wrapping/RL1,
// incrementing/RL2) driven in turn and checked against a word-array memory model.
module tb_avalon_burst_bram;

   logic        clk = 1'b0;
   logic        rst   [3];
   logic [31:0] addr  [3];
   logic        rd    [3];
   logic        wr    [3];
   logic [3:0]  bc    [3];
   logic [3:0]  be    [3];
   logic [31:0] wd    [3];
   logic [31:0] rdata [3];
   logic        rdv   [3];
   logic        wreq  [3];

   logic [31:0] rmem [3][256];
   int          cmp = 0;
   int          err = 0;

   always #5 clk = ~clk;

   avalon_burst_bram #(.WRAP_BURST(0), .READ_LATENCY(1)) u_inc (
      .clk(clk), .reset(rst[0]), .address(addr[0]), .read(rd[0]), .write(wr[0]),
      .burstcount(bc[0]), .byteenable(be[0]), .writedata(wd[0]),
      .readdata(rdata[0]), .readdatavalid(rdv[0]), .waitrequest(wreq[0]));

   avalon_burst_bram #(.WRAP_BURST(1), .READ_LATENCY(1)) u_wrap (
      .clk(clk), .reset(rst[1]), .address(addr[1]), .read(rd[1]), .write(wr[1]),
      .burstcount(bc[1]), .byteenable(be[1]), .writedata(wd[1]),
      .readdata(rdata[1]), .readdatavalid(rdv[1]), .waitrequest(wreq[1]));

   avalon_burst_bram #(.WRAP_BURST(0), .READ_LATENCY(2)) u_rl2 (
      .clk(clk), .reset(rst[2]), .address(addr[2]), .read(rd[2]), .write(wr[2]),
      .burstcount(bc[2]), .byteenable(be[2]), .writedata(wd[2]),
      .readdata(rdata[2]), .readdatavalid(rdv[2]), .waitrequest(wreq[2]));

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      cmp++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int rl_of(int d);
      return (d == 2) ? 2 : 1;
   endfunction

   // Word touched by beat k of a burst starting at word 'start'.
   function automatic int widx(int d, int start, int k);
      if (d == 1) return (start / 8) * 8 + (start + k) % 8;
      return (start + k) % 256;
   endfunction

   // mode 0: fixed data/byteenable; 1: random data, full lanes; 2: random data,
   // lanes, stalls and stray read requests.
   task automatic do_write(int d, logic [31:0] a, int bcv, logic [31:0] d0,
                           logic [3:0] be0, int mode, int stall_at);
      int          len, start, idx;
      logic [31:0] dv;
      logic [3:0]  bv;
      len   = (bcv == 0) ? 1 : bcv;
      start = int'(a[9:2]);
      for (int k = 0; k < len; k++) begin
         dv = (mode == 0) ? d0 : $urandom;
         bv = (mode == 2) ? 4'($urandom) : ((mode == 1) ? 4'hF : be0);
         addr[d] = (k == 0) ? a : $urandom;
         bc[d]   = (k == 0) ? 4'(bcv) : 4'($urandom);
         wr[d]   = 1'b1;
         wd[d]   = dv;
         be[d]   = bv;
         rd[d]   = (mode == 2) ? 1'($urandom) : 1'b0;
         @(negedge clk);
         chk($sformatf("d%0d wr_wait beat%0d", d, k), 32'(wreq[d]), 32'd0);
         chk($sformatf("d%0d wr_no_rdv beat%0d", d, k), 32'(rdv[d]), 32'd0);
         @(posedge clk); #1;
         idx = widx(d, start, k);
         for (int b = 0; b < 4; b++)
            if (bv[b]) rmem[d][idx][8*b +: 8] = dv[8*b +: 8];
         if (k < len - 1 && (k == stall_at || (mode == 2 && $urandom_range(3) == 0))) begin
            wr[d] = 1'b0;
            rd[d] = (mode == 2) ? 1'($urandom) : 1'b0;
            wd[d] = $urandom;
            @(negedge clk);
            chk($sformatf("d%0d wr_stall_wait", d), 32'(wreq[d]), 32'd0);
            @(posedge clk); #1;
         end
      end
      wr[d] = 1'b0;
      rd[d] = 1'b0;
   endtask

   task automatic do_read(int d, logic [31:0] a, int bcv);
      int          len, start, rl;
      logic        ev, ew;
      logic [31:0] ed;
      len   = (bcv == 0) ? 1 : bcv;
      start = int'(a[9:2]);
      rl    = rl_of(d);
      addr[d] = a;
      bc[d]   = 4'(bcv);
      rd[d]   = 1'b1;
      wr[d]   = 1'b0;
      @(negedge clk);
      chk($sformatf("d%0d rd_accept_wait", d), 32'(wreq[d]), 32'd0);
      @(posedge clk); #1;
      rd[d]   = 1'b0;
      addr[d] = $urandom;
      bc[d]   = 4'($urandom);
      for (int j = 1; j <= rl + len; j++) begin
         @(negedge clk);
         ev = (j >= rl) && (j < rl + len);
         ew = (j < rl + len);
         ed = ev ? rmem[d][widx(d, start, j - rl)] : 32'd0;
         chk($sformatf("d%0d rd_valid c%0d", d, j), 32'(rdv[d]), 32'(ev));
         chk($sformatf("d%0d rd_data c%0d", d, j), rdata[d], ed);
         chk($sformatf("d%0d rd_wait c%0d", d, j), 32'(wreq[d]), 32'(ew));
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; addr[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0;
         bc[d] = '0; be[d] = '0; wd[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d reset_wait", d), 32'(wreq[d]), 32'd1);
         chk($sformatf("d%0d reset_rdv", d), 32'(rdv[d]), 32'd0);
         chk($sformatf("d%0d reset_rdata", d), rdata[d], 32'd0);
      end
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk($sformatf("d%0d post_rst_wait", d), 32'(wreq[d]), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk($sformatf("d%0d idle_wait", d), 32'(wreq[d]), 32'd0);
      @(posedge clk); #1;

      // Fill every word so later reads compare against known data.
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 32; i++) do_write(d, 32'(i * 32), 8, 32'd0, 4'hF, 1, -1);

      // Single write then single read.
      do_write(0, 32'h10, 1, 32'hDEADBEEF, 4'hF, 0, -1);
      do_read(0, 32'h10, 1);

      // Burst across the top of memory with a stall between beats 2 and 3.
      do_write(0, 32'h3F8, 4, 32'd0, 4'hF, 1, 1);
      do_read(0, 32'h3F8, 4);

      // Partial byte enables.
      do_write(0, 32'h40, 1, 32'h11223344, 4'hF, 0, -1);
      do_write(0, 32'h40, 1, 32'hAABBCCDD, 4'h5, 0, -1);
      do_read(0, 32'h40, 1);

      // burstcount 0 behaves as a single beat.
      do_write(0, 32'h80, 0, 32'h0BADF00D, 4'hF, 0, -1);
      do_read(0, 32'h80, 2);

      // Read and write together in IDLE: write wins, read is dropped.
      addr[0] = 32'h20; bc[0] = 4'd1; be[0] = 4'hF; wd[0] = 32'hCAFE0001;
      wr[0] = 1'b1; rd[0] = 1'b1;
      @(negedge clk);
      chk("d0 rw_wait", 32'(wreq[0]), 32'd0);
      @(posedge clk); #1;
      rmem[0][8] = 32'hCAFE0001;
      wr[0] = 1'b0; rd[0] = 1'b0;
      @(negedge clk);
      chk("d0 rw_no_read_rdv", 32'(rdv[0]), 32'd0);
      chk("d0 rw_no_read_wait", 32'(wreq[0]), 32'd0);
      @(posedge clk); #1;
      do_read(0, 32'h20, 1);

      // Wrapping burst from word 5 and a latency-2 burst.
      do_read(1, 32'h14, 8);
      do_read(2, 32'h40, 3);

      // Randomised traffic on each instance.
      for (int d = 0; d < 3; d++)
         for (int n = 0; n < 14; n++) begin
            if ($urandom_range(1) == 0)
               do_write(d, $urandom, int'($urandom_range(8)), 32'd0, 4'hF, 2, -1);
            else
               do_read(d, $urandom, int'($urandom_range(8)));
         end

      // Reset during beat 2 of an 8-beat read.
      addr[0] = 32'h100; bc[0] = 4'd8; rd[0] = 1'b1;
      @(posedge clk); #1;
      rd[0] = 1'b0;
      @(negedge clk);
      chk("d0 abort_rd_beat0_rdv", 32'(rdv[0]), 32'd1);
      chk("d0 abort_rd_beat0_data", rdata[0], rmem[0][64]);
      @(posedge clk); #1;
      rst[0] = 1'b1;
      @(negedge clk);
      chk("d0 abort_rd_rdv", 32'(rdv[0]), 32'd0);
      chk("d0 abort_rd_data", rdata[0], 32'd0);
      chk("d0 abort_rd_wait", 32'(wreq[0]), 32'd1);
      @(posedge clk); #1;
      rst[0] = 1'b0;
      @(negedge clk);
      chk("d0 abort_post_rst_wait", 32'(wreq[0]), 32'd1);
      chk("d0 abort_post_rst_rdv", 32'(rdv[0]), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("d0 abort_idle_wait", 32'(wreq[0]), 32'd0);
      chk("d0 abort_idle_rdv", 32'(rdv[0]), 32'd0);
      @(posedge clk); #1;
      do_read(0, 32'h100, 8);

      // Reset during a write burst: beat 0 lands, the rest never does.
      addr[0] = 32'h200; bc[0] = 4'd4; be[0] = 4'hF; wd[0] = 32'h5A5A0000; wr[0] = 1'b1;
      @(posedge clk); #1;
      rmem[0][128] = 32'h5A5A0000;
      wd[0] = 32'h5A5A0001; rst[0] = 1'b1;
      @(negedge clk);
      chk("d0 abort_wr_wait", 32'(wreq[0]), 32'd1);
      @(posedge clk); #1;
      rst[0] = 1'b0; wd[0] = 32'h5A5A0002;
      @(negedge clk);
      chk("d0 abort_wr_post_rst_wait", 32'(wreq[0]), 32'd1);
      @(posedge clk); #1;
      wr[0] = 1'b0;
      do_read(0, 32'h200, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end

endmodule
